arcade_audio_mixer: RTL and testbench
=====================================

// Module: arcade_audio_mixer
// PURPOSE
//  Parametrised N-channel audio mixer for arcade cores. It replaces fixed wire-sum mixing, such as the
//  three 8-bit sound outputs summed into an 11-bit bus.
//  On each sample strobe it snapshots all channels and converts unsigned inputs to signed. It then applies
//  a per-channel shift gain and mute, accumulates sequentially, and saturates to a signed OUT_W sample.
//  The output feeds the i2s/sigma-delta output stage.
// PARAMETERS
//  NUM_CH   4   number of input channels (1..16)
//  IN_W     8   bits per input channel
//  OUT_W    16  signed output sample width (OUT_W >= IN_W)
//  GAIN_W   3   bits of per-channel left-shift gain (shift 0..2^GAIN_W-1)
// PORTS
//  clk_sys     in   1               system clock
//  reset       in   1               asynchronous, active-high reset
//  ce_sample   in   1               1-cycle strobe: start mixing one output sample
//  signed_in   in   1               0 = inputs offset-binary (unsigned), 1 = two's complement
//  ch_in       in   NUM_CH*IN_W     channel samples; ch k at [k*IN_W +: IN_W]
//  ch_gain     in   NUM_CH*GAIN_W   per-channel left-shift amount
//  ch_mute     in   NUM_CH          1 = channel contributes 0
//  out_sample  out  OUT_W           signed mixed sample, held between updates
//  out_valid   out  1               1-cycle pulse when out_sample updates
//  busy        out  1               high from the cycle after an accepted ce_sample until out_valid
//  clip        out  1               1-cycle pulse with out_valid if saturation occurred
//  missed      out  1               1-cycle pulse when ce_sample arrives while busy
// BEHAVIOUR
//  Reset (async assert; deassertion is synchronised by the parent): out_sample=0, out_valid=0, busy=0,
//   clip=0, missed=0. State returns to IDLE and the accumulator clears.
//  FSM states IDLE, ACCUM, SAT.
//   IDLE: when ce_sample=1, register ch_in/ch_gain/ch_mute/signed_in into snapshot registers,
//    set idx=0 and acc=0, then go to ACCUM.
//   ACCUM: each cycle, acc += term(idx) and idx++. After idx=NUM_CH-1, go to SAT. This takes exactly NUM_CH cycles.
//   SAT: register the saturated acc into out_sample, pulse out_valid (and clip if clamped), then go to IDLE.
//  Latency: out_valid occurs NUM_CH+1 cycles after the ce_sample cycle. The next ce_sample is accepted in the same cycle as out_valid.
//  term(k):
//   s = signed_in ? ch_in[k] : {~msb, rest}, i.e. subtract 2^(IN_W-1).
//   term = mute[k] ? 0 : sign_extend(s) <<< gain[k].
//  acc width ACC_W = IN_W + 2^GAIN_W - 1 + $clog2(NUM_CH) + 1, so no internal overflow is possible.
//  Saturation: if acc > 2^(OUT_W-1)-1, output the max and set clip=1. If acc < -2^(OUT_W-1), output the min and set clip=1.
//   Otherwise output acc unchanged (no implicit scaling; the parent chooses the gains).
//  Inputs are used only from the snapshot, so changes to ch_in during ACCUM/SAT have no effect.
//  ce_sample while busy: ignored. missed pulses the next cycle and the current mix completes unchanged.
//   ce_sample in the same cycle as out_valid is accepted, not missed.
//  NUM_CH=1: ACCUM lasts 1 cycle, giving a latency of 2.
//  Reset asserted mid-ACCUM: the mix is discarded and no out_valid is produced after reset is released.
// TESTING (defaults NUM_CH=4, IN_W=8, OUT_W=16, GAIN_W=3)
//  1. signed_in=0, all ch=0x80, gain 0, no mute, ce_sample -> out_valid at +5 cycles, out_sample=0, clip=0.
//  2. signed_in=0, ch0=0xFF, others 0x80, gain0=2 -> out_sample=508 (127<<2), clip=0.
//  3. signed_in=0, all ch=0xFF, gain 7 -> sum 65024 is clamped -> out_sample=32767 (0x7FFF), clip=1 for one cycle.
//  4. signed_in=1, all ch=0x80, gain 7 -> sum -65536 is clamped -> out_sample=-32768 (0x8000), clip=1.
//     Repeat with ch_mute=4'b1110 -> out_sample=-16384, clip=0.
//  5. ce_sample 2 cycles after an accepted one -> missed=1 for one cycle and the first result is unchanged.
//     ce_sample coincident with out_valid -> accepted, busy stays high, next out_valid 5 cycles later.
//  6. Assert reset during ACCUM (idx=2) -> outputs read 0 immediately and no out_valid follows.
//     Change ch_in during ACCUM -> the result matches the snapshot values.

Source files
------------

// File: rtl/arcade_audio_mixer.sv
`default_nettype none
// ============================================================================
// Module   : arcade_audio_mixer
// Purpose  : N-channel sequential audio mixer with per-channel shift gain,
//            mute, offset-binary conversion and signed output saturation.
// Revision : 1.0 - initial release
// ============================================================================
module arcade_audio_mixer #(
    parameter int NUM_CH = 4,
    parameter int IN_W   = 8,
    parameter int OUT_W  = 16,
    parameter int GAIN_W = 3
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     ce_sample,
    input  logic                     signed_in,
    input  logic [NUM_CH*IN_W-1:0]   ch_in,
    input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
    input  logic [NUM_CH-1:0]        ch_mute,
    output logic [OUT_W-1:0]         out_sample,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     clip,
    output logic                     missed
);

    localparam int C_ACC_W = IN_W + (2 ** GAIN_W) - 1 + $clog2(NUM_CH) + 1;
    localparam int C_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int C_EXT_W = (C_ACC_W > OUT_W) ? C_ACC_W : OUT_W;

    localparam logic [C_IDX_W-1:0]        C_LAST = C_IDX_W'(NUM_CH - 1);
    localparam logic signed [C_EXT_W-1:0] C_MAX  =
        {{(C_EXT_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [C_EXT_W-1:0] C_MIN  = ~C_MAX;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SAT   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [NUM_CH-1:0][IN_W-1:0]   r_ch;
    logic [NUM_CH-1:0][GAIN_W-1:0] r_gain;
    logic [NUM_CH-1:0]             r_mute;
    logic                          r_signed;
    logic [C_IDX_W-1:0]            r_idx;
    logic signed [C_ACC_W-1:0]     r_acc;

    logic [IN_W-1:0]               w_sel;
    logic signed [IN_W-1:0]        w_s;
    logic signed [C_ACC_W-1:0]     w_s_ext;
    logic signed [C_ACC_W-1:0]     w_term;
    logic signed [C_ACC_W-1:0]     w_acc_next;
    logic signed [C_EXT_W-1:0]     w_acc_ext;
    logic                          w_hi;
    logic                          w_lo;
    logic [OUT_W-1:0]              w_sat;
    logic                          w_last;
    logic                          w_accept;

    // Offset-binary to two's complement is just an MSB flip.
    assign w_sel      = r_ch[r_idx];
    assign w_s        = {w_sel[IN_W-1] ^ ~r_signed, w_sel[IN_W-2:0]};
    assign w_s_ext    = C_ACC_W'(w_s);
    assign w_term     = r_mute[r_idx] ? '0 : (w_s_ext <<< r_gain[r_idx]);
    assign w_acc_next = r_acc + w_term;
    assign w_acc_ext  = C_EXT_W'(w_acc_next);
    assign w_hi       = (w_acc_ext > C_MAX);
    assign w_lo       = (w_acc_ext < C_MIN);
    assign w_sat      = w_hi ? C_MAX[OUT_W-1:0] :
                        w_lo ? C_MIN[OUT_W-1:0] : w_acc_ext[OUT_W-1:0];
    assign w_last     = (r_state == ST_ACCUM) && (r_idx == C_LAST);
    // SAT is the out_valid cycle, so a new strobe is taken there as in IDLE.
    assign w_accept   = ce_sample && (r_state != ST_ACCUM);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE:  w_next = w_accept ? ST_ACCUM : ST_IDLE;
            ST_ACCUM: w_next = w_last   ? ST_SAT   : ST_ACCUM;
            ST_SAT:   w_next = w_accept ? ST_ACCUM : ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_ch       <= '0;
            r_gain     <= '0;
            r_mute     <= '0;
            r_signed   <= 1'b0;
            r_idx      <= '0;
            r_acc      <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            clip       <= 1'b0;
            missed     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            clip      <= 1'b0;
            missed    <= ce_sample && (r_state == ST_ACCUM);
            if (w_accept) begin
                r_ch     <= ch_in;
                r_gain   <= ch_gain;
                r_mute   <= ch_mute;
                r_signed <= signed_in;
                r_idx    <= '0;
                r_acc    <= '0;
            end else if (r_state == ST_ACCUM) begin
                r_acc <= w_acc_next;
                r_idx <= r_idx + C_IDX_W'(1);
                if (w_last) begin
                    out_sample <= w_sat;
                    out_valid  <= 1'b1;
                    clip       <= w_hi | w_lo;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arcade_audio_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_arcade_audio_mixer
// Purpose  : Directed vector bench for arcade_audio_mixer (4ch, 8b in, 16b out).
// Revision : 1.0 - initial release
// ============================================================================
module tb_arcade_audio_mixer;

    localparam int C_NUM_CH = 4;
    localparam int C_IN_W   = 8;
    localparam int C_OUT_W  = 16;
    localparam int C_GAIN_W = 3;
    localparam int C_NVEC   = 11;

    logic                         clk_sys = 1'b0;
    logic                         reset;
    logic                         ce_sample;
    logic                         signed_in;
    logic [C_NUM_CH*C_IN_W-1:0]   ch_in;
    logic [C_NUM_CH*C_GAIN_W-1:0] ch_gain;
    logic [C_NUM_CH-1:0]          ch_mute;
    logic [C_OUT_W-1:0]           out_sample;
    logic                         out_valid;
    logic                         busy;
    logic                         clip;
    logic                         missed;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      name;
        logic       sgn;
        logic [31:0] ch;
        logic [11:0] gain;
        logic [3:0]  mute;
        int         exp_sample;
        logic       exp_clip;
    } vec_t;

    vec_t vecs [C_NVEC];

    arcade_audio_mixer #(
        .NUM_CH (C_NUM_CH),
        .IN_W   (C_IN_W),
        .OUT_W  (C_OUT_W),
        .GAIN_W (C_GAIN_W)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ce_sample  (ce_sample),
        .signed_in  (signed_in),
        .ch_in      (ch_in),
        .ch_gain    (ch_gain),
        .ch_mute    (ch_mute),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .busy       (busy),
        .clip       (clip),
        .missed     (missed)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        signed_in = v.sgn;
        ch_in     = v.ch;
        ch_gain   = v.gain;
        ch_mute   = v.mute;
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic run_mix(input string name, input int exp, input logic exp_clip);
        int n;
        ce_sample = 1'b1;
        tick();
        ce_sample = 1'b0;
        check({name, " busy"}, int'(busy), 1);
        wait_valid(n);
        check({name, " latency"}, n, 5);
        check({name, " sample"}, int'($signed(out_sample)), exp);
        check({name, " clip"}, int'(clip), int'(exp_clip));
        tick();
        check({name, " valid pulse"}, int'(out_valid), 0);
        check({name, " clip pulse"}, int'(clip), 0);
        check({name, " idle"}, int'(busy), 0);
    endtask

    initial begin
        int n;
        int seen;

        vecs[0]  = '{"zero_mid",   1'b0, 32'h80808080, 12'h000, 4'h0,      0, 1'b0};
        vecs[1]  = '{"gain2",      1'b0, 32'h808080FF, 12'h002, 4'h0,    508, 1'b0};
        vecs[2]  = '{"clip_hi",    1'b0, 32'hFFFFFFFF, 12'hFFF, 4'h0,  32767, 1'b1};
        vecs[3]  = '{"clip_lo",    1'b1, 32'h80808080, 12'hFFF, 4'h0, -32768, 1'b1};
        vecs[4]  = '{"mute1110",   1'b1, 32'h80808080, 12'hFFF, 4'hE, -16384, 1'b0};
        vecs[5]  = '{"signed_sum", 1'b1, 32'h04030201, 12'h000, 4'h0,     10, 1'b0};
        vecs[6]  = '{"mixed",      1'b1, 32'h8010FF7F, 12'h019, 4'h8,    262, 1'b0};
        vecs[7]  = '{"u_zero",     1'b0, 32'h00000000, 12'h000, 4'h0,   -512, 1'b0};
        vecs[8]  = '{"min_exact",  1'b0, 32'h00000000, 12'hDB6, 4'h0, -32768, 1'b0};
        vecs[9]  = '{"max_exact",  1'b0, 32'h81FFFFFF, 12'h07F, 4'h0,  32767, 1'b0};
        vecs[10] = '{"max_plus1",  1'b0, 32'h8082FFFF, 12'hFFF, 4'h0,  32767, 1'b1};

        reset     = 1'b1;
        ce_sample = 1'b0;
        apply(vecs[0]);
        repeat (3) tick();
        check("reset out_sample", int'(out_sample), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset busy", int'(busy), 0);
        check("reset clip", int'(clip), 0);
        check("reset missed", int'(missed), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < C_NVEC; i++) begin
            apply(vecs[i]);
            run_mix(vecs[i].name, vecs[i].exp_sample, vecs[i].exp_clip);
        end

        // Strobe two cycles into a mix: flagged, result untouched.
        apply(vecs[1]);
        ce_sample = 1'b1;
        tick();
        ce_sample = 1'b0;
        tick();
        apply(vecs[2]);
        ce_sample = 1'b1;
        tick();
        ce_sample = 1'b0;
        check("missed pulse", int'(missed), 1);
        tick();
        check("missed one cycle", int'(missed), 0);
        check("missed no early valid", int'(out_valid), 0);
        tick();
        check("missed valid", int'(out_valid), 1);
        check("missed sample", int'($signed(out_sample)), 508);
        tick();
        check("missed no second valid", int'(out_valid), 0);

        // Strobe coincident with out_valid is accepted back-to-back.
        apply(vecs[1]);
        ce_sample = 1'b1;
        tick();
        ce_sample = 1'b0;
        repeat (4) tick();
        check("b2b first valid", int'(out_valid), 1);
        check("b2b first sample", int'($signed(out_sample)), 508);
        apply(vecs[5]);
        ce_sample = 1'b1;
        tick();
        ce_sample = 1'b0;
        check("b2b busy held", int'(busy), 1);
        check("b2b not missed", int'(missed), 0);
        check("b2b valid dropped", int'(out_valid), 0);
        wait_valid(n);
        check("b2b second latency", n, 5);
        check("b2b second sample", int'($signed(out_sample)), 10);
        tick();

        // Reset while idx=2: outputs clear at once, mix is lost.
        apply(vecs[1]);
        ce_sample = 1'b1;
        tick();
        ce_sample = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("midreset out_sample", int'(out_sample), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset out_valid", int'(out_valid), 0);
        tick();
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid) seen++;
        end
        check("midreset no valid after", seen, 0);
        check("midreset idle", int'(busy), 0);

        // Inputs change after the snapshot: result follows the snapshot.
        apply(vecs[6]);
        ce_sample = 1'b1;
        tick();
        ce_sample = 1'b0;
        signed_in = 1'b0;
        ch_in     = '1;
        ch_gain   = '1;
        ch_mute   = '0;
        wait_valid(n);
        check("snapshot latency", n, 5);
        check("snapshot sample", int'($signed(out_sample)), 262);
        check("snapshot clip", int'(clip), 0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
